// File: rtl/multi_debouncer_if.sv
// Button bundle between the raw board inputs and the debouncer.
// The master side drives the raw buttons; the slave side returns clean levels and edge pulses.
interface multi_debouncer_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] i_btn;
  logic [NUM_CH-1:0] o_btn_state;
  logic [NUM_CH-1:0] o_press;
  logic [NUM_CH-1:0] o_release;

  modport master (
    output i_btn,
    input  o_btn_state,
    input  o_press,
    input  o_release
  );

  modport slave (
    input  i_btn,
    output o_btn_state,
    output o_press,
    output o_release
  );
endinterface

// File: rtl/multi_debouncer.sv
// Multi-channel push-button debouncer: synchroniser, polarity normalisation and a
// symmetric per-channel stability FSM producing a clean level plus press/release pulses.
module multi_debouncer #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int ACTIVE_LOW  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  multi_debouncer_if.slave   bus
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } state_e;

  localparam logic              AL_BIT   = (ACTIVE_LOW != 0);
  localparam logic [NUM_CH-1:0] SYNC_RST = {NUM_CH{AL_BIT}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_d [SYNC_STAGES];
  logic [NUM_CH-1:0] norm;

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];

  logic [NUM_CH-1:0] btn_state_q, btn_state_d;
  logic [NUM_CH-1:0] press_q, press_d;
  logic [NUM_CH-1:0] release_q, release_d;

  // Synchroniser chain; flops idle at the inactive raw level so reset exit is quiet
  always_comb begin
    sync_d[0] = bus.i_btn;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= SYNC_RST;
      end
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  assign norm = sync_q[SYNC_STAGES-1] ^ {NUM_CH{AL_BIT}};

  // Per-channel stability FSM; a level reversal always wins over the terminal count
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      state_d[k]   = state_q[k];
      cnt_d[k]     = '0;
      press_d[k]   = 1'b0;
      release_d[k] = 1'b0;
      case (state_q[k])
        STABLE_LO: begin
          if (norm[k]) state_d[k] = CHECK_HI;
        end
        CHECK_HI: begin
          if (!norm[k]) begin
            state_d[k] = STABLE_LO;
          end else if (cnt_q[k] == CNT_MAX) begin
            state_d[k] = STABLE_HI;
            press_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!norm[k]) state_d[k] = CHECK_LO;
        end
        CHECK_LO: begin
          if (norm[k]) begin
            state_d[k] = STABLE_HI;
          end else if (cnt_q[k] == CNT_MAX) begin
            state_d[k]   = STABLE_LO;
            release_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_ONE;
          end
        end
        default: state_d[k] = STABLE_LO;
      endcase
      btn_state_d[k] = (state_d[k] == STABLE_HI) || (state_d[k] == CHECK_LO);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= STABLE_LO;
        cnt_q[k]   <= '0;
      end
      btn_state_q <= '0;
      press_q     <= '0;
      release_q   <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      btn_state_q <= btn_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  assign bus.o_btn_state = btn_state_q;
  assign bus.o_press     = press_q;
  assign bus.o_release   = release_q;

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench: dut0 is a 2-channel active-high debouncer, dut1 a 1-channel
// active-low one; both use a 16-cycle stability window and a 2-stage synchroniser.
module tb_multi_debouncer;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  int   pc0 [2];
  int   rc0 [2];
  int   pc1;
  int   rc1;
  int   ovl;

  multi_debouncer_if #(.NUM_CH(2)) bus0 ();
  multi_debouncer_if #(.NUM_CH(1)) bus1 ();

  multi_debouncer #(
    .NUM_CH(2), .CNT_W(4), .ACTIVE_LOW(0), .SYNC_STAGES(2)
  ) dut0 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus0)
  );

  multi_debouncer #(
    .NUM_CH(1), .CNT_W(4), .ACTIVE_LOW(1), .SYNC_STAGES(2)
  ) dut1 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus1)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (bus0.o_press[k])   pc0[k] <= pc0[k] + 1;
      if (bus0.o_release[k]) rc0[k] <= rc0[k] + 1;
    end
    if (bus1.o_press[0])   pc1 <= pc1 + 1;
    if (bus1.o_release[0]) rc1 <= rc1 + 1;
    if ((bus0.o_press & bus0.o_release) != 2'b00 || (bus1.o_press & bus1.o_release) != 1'b0)
      ovl <= ovl + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus0.i_btn = 2'(i);
      bus1.i_btn = 1'(i);
      step(1);
    end
    tests++;
    if (bus0.o_btn_state !== 2'b00 || bus0.o_press !== 2'b00 || bus0.o_release !== 2'b00) begin
      fails++;
      $display("FAIL reset_dut0: state=%b press=%b release=%b expected all 0",
               bus0.o_btn_state, bus0.o_press, bus0.o_release);
    end
    tests++;
    if (bus1.o_btn_state !== 1'b0 || bus1.o_press !== 1'b0 || bus1.o_release !== 1'b0) begin
      fails++;
      $display("FAIL reset_dut1: state=%b press=%b release=%b expected all 0",
               bus1.o_btn_state, bus1.o_press, bus1.o_release);
    end
    bus0.i_btn = 2'b00;
    bus1.i_btn = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(25);
    tests++;
    if (pc0[0] + pc0[1] + rc0[0] + rc0[1] + pc1 + rc1 !== 0) begin
      fails++;
      $display("FAIL reset_exit_pulses: got %0d pulses expected 0",
               pc0[0] + pc0[1] + rc0[0] + rc0[1] + pc1 + rc1);
    end
    tests++;
    if (bus0.o_btn_state !== 2'b00 || bus1.o_btn_state !== 1'b0) begin
      fails++;
      $display("FAIL reset_exit_state: dut0=%b dut1=%b expected 00/0",
               bus0.o_btn_state, bus1.o_btn_state);
    end
  endtask

  task automatic test_clean_press();
    bus0.i_btn = 2'b01;
    step(18);
    tests++;
    if (bus0.o_btn_state !== 2'b00) begin
      fails++;
      $display("FAIL press_early: state=%b expected 00", bus0.o_btn_state);
    end
    step(1);
    tests++;
    if (bus0.o_btn_state !== 2'b01 || bus0.o_press !== 2'b01 || bus0.o_release !== 2'b00) begin
      fails++;
      $display("FAIL press_edge: state=%b press=%b release=%b expected 01/01/00",
               bus0.o_btn_state, bus0.o_press, bus0.o_release);
    end
    step(1);
    tests++;
    if (bus0.o_btn_state !== 2'b01 || bus0.o_press !== 2'b00) begin
      fails++;
      $display("FAIL press_width: state=%b press=%b expected 01/00",
               bus0.o_btn_state, bus0.o_press);
    end
    step(30);
    tests++;
    if (pc0[0] !== 1 || pc0[1] !== 0) begin
      fails++;
      $display("FAIL press_hold_once: presses ch0=%0d ch1=%0d expected 1/0", pc0[0], pc0[1]);
    end
    bus0.i_btn = 2'b00;
    step(19);
    tests++;
    if (bus0.o_btn_state !== 2'b00 || bus0.o_release !== 2'b01 || bus0.o_press !== 2'b00) begin
      fails++;
      $display("FAIL release_edge: state=%b release=%b press=%b expected 00/01/00",
               bus0.o_btn_state, bus0.o_release, bus0.o_press);
    end
    step(1);
    tests++;
    if (bus0.o_release !== 2'b00) begin
      fails++;
      $display("FAIL release_width: release=%b expected 00", bus0.o_release);
    end
  endtask

  task automatic test_bounce();
    int p0;
    int r0;
    int lvl [6] = '{1, 0, 1, 0, 1, 0};
    int dur [6] = '{1, 2, 3, 1, 2, 1};
    p0 = pc0[0];
    bus0.i_btn = 2'b01;
    step(16);
    bus0.i_btn = 2'b00;
    step(25);
    tests++;
    if (pc0[0] - p0 !== 0 || bus0.o_btn_state !== 2'b00) begin
      fails++;
      $display("FAIL bounce_16: presses=%0d state=%b expected 0/00", pc0[0] - p0, bus0.o_btn_state);
    end
    p0 = pc0[0];
    r0 = rc0[0];
    bus0.i_btn = 2'b01;
    step(17);
    bus0.i_btn = 2'b00;
    step(40);
    tests++;
    if (pc0[0] - p0 !== 1 || rc0[0] - r0 !== 1 || bus0.o_btn_state !== 2'b00) begin
      fails++;
      $display("FAIL bounce_17: presses=%0d releases=%0d state=%b expected 1/1/00",
               pc0[0] - p0, rc0[0] - r0, bus0.o_btn_state);
    end
    p0 = pc0[0];
    for (int i = 0; i < 6; i++) begin
      bus0.i_btn = {1'b0, 1'(lvl[i])};
      step(dur[i]);
    end
    bus0.i_btn = 2'b01;
    step(18);
    tests++;
    if (pc0[0] - p0 !== 0 || bus0.o_btn_state !== 2'b00) begin
      fails++;
      $display("FAIL bounce_train_early: presses=%0d state=%b expected 0/00",
               pc0[0] - p0, bus0.o_btn_state);
    end
    step(1);
    tests++;
    if (bus0.o_btn_state !== 2'b01 || bus0.o_press !== 2'b01) begin
      fails++;
      $display("FAIL bounce_train_edge: state=%b press=%b expected 01/01",
               bus0.o_btn_state, bus0.o_press);
    end
    step(10);
    tests++;
    if (pc0[0] - p0 !== 1) begin
      fails++;
      $display("FAIL bounce_train_count: presses=%0d expected 1", pc0[0] - p0);
    end
    bus0.i_btn = 2'b00;
    step(25);
  endtask

  task automatic test_simultaneous();
    int p0;
    int p1;
    int r0;
    int r1;
    p0 = pc0[0]; p1 = pc0[1]; r0 = rc0[0]; r1 = rc0[1];
    bus0.i_btn = 2'b11;
    step(19);
    tests++;
    if (bus0.o_press !== 2'b11 || bus0.o_btn_state !== 2'b11) begin
      fails++;
      $display("FAIL simul_press: press=%b state=%b expected 11/11", bus0.o_press, bus0.o_btn_state);
    end
    step(1);
    tests++;
    if (bus0.o_press !== 2'b00) begin
      fails++;
      $display("FAIL simul_press_width: press=%b expected 00", bus0.o_press);
    end
    step(5);
    bus0.i_btn = 2'b00;
    step(19);
    tests++;
    if (bus0.o_release !== 2'b11 || bus0.o_btn_state !== 2'b00) begin
      fails++;
      $display("FAIL simul_release: release=%b state=%b expected 11/00",
               bus0.o_release, bus0.o_btn_state);
    end
    step(20);
    tests++;
    if (pc0[0] - p0 !== 1 || pc0[1] - p1 !== 1 || rc0[0] - r0 !== 1 || rc0[1] - r1 !== 1) begin
      fails++;
      $display("FAIL simul_counts: press=%0d/%0d release=%0d/%0d expected 1/1 1/1",
               pc0[0] - p0, pc0[1] - p1, rc0[0] - r0, rc0[1] - r1);
    end
  endtask

  task automatic test_polarity();
    int p;
    int r;
    p = pc1; r = rc1;
    bus1.i_btn = 1'b0;
    step(18);
    tests++;
    if (bus1.o_btn_state !== 1'b0) begin
      fails++;
      $display("FAIL pol_early: state=%b expected 0", bus1.o_btn_state);
    end
    step(1);
    tests++;
    if (bus1.o_btn_state !== 1'b1 || bus1.o_press !== 1'b1) begin
      fails++;
      $display("FAIL pol_press: state=%b press=%b expected 1/1", bus1.o_btn_state, bus1.o_press);
    end
    step(5);
    bus1.i_btn = 1'b1;
    step(19);
    tests++;
    if (bus1.o_btn_state !== 1'b0 || bus1.o_release !== 1'b1) begin
      fails++;
      $display("FAIL pol_release: state=%b release=%b expected 0/1", bus1.o_btn_state, bus1.o_release);
    end
    step(5);
    tests++;
    if (pc1 - p !== 1 || rc1 - r !== 1) begin
      fails++;
      $display("FAIL pol_counts: press=%0d release=%0d expected 1/1", pc1 - p, rc1 - r);
    end
  endtask

  task automatic test_reset_mid_count();
    int p0;
    int p1;
    int q1;
    int s1;
    bus0.i_btn = 2'b10;
    step(20);
    tests++;
    if (bus0.o_btn_state !== 2'b10) begin
      fails++;
      $display("FAIL rmid_setup: state=%b expected 10", bus0.o_btn_state);
    end
    bus0.i_btn = 2'b11;
    step(13);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus0.o_btn_state !== 2'b00 || bus0.o_press !== 2'b00 || bus0.o_release !== 2'b00) begin
      fails++;
      $display("FAIL rmid_async: state=%b press=%b release=%b expected 00/00/00",
               bus0.o_btn_state, bus0.o_press, bus0.o_release);
    end
    step(3);
    p0 = pc0[0]; p1 = pc0[1]; q1 = pc1; s1 = rc1;
    rst_n = 1'b1;
    step(18);
    tests++;
    if (bus0.o_btn_state !== 2'b00) begin
      fails++;
      $display("FAIL rmid_no_partial: state=%b expected 00", bus0.o_btn_state);
    end
    step(1);
    tests++;
    if (bus0.o_btn_state !== 2'b11 || bus0.o_press !== 2'b11) begin
      fails++;
      $display("FAIL rmid_full_count: state=%b press=%b expected 11/11",
               bus0.o_btn_state, bus0.o_press);
    end
    step(3);
    tests++;
    if (pc0[0] - p0 !== 1 || pc0[1] - p1 !== 1 || pc1 - q1 !== 0 || rc1 - s1 !== 0) begin
      fails++;
      $display("FAIL rmid_counts: dut0 press=%0d/%0d dut1 press=%0d release=%0d expected 1/1 0 0",
               pc0[0] - p0, pc0[1] - p1, pc1 - q1, rc1 - s1);
    end
    bus0.i_btn = 2'b00;
    step(25);
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    tests = 0;
    fails = 0;
    bus0.i_btn = 2'b00;
    bus1.i_btn = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_polarity();
    test_reset_mid_count();
    tests++;
    if (ovl !== 0) begin
      fails++;
      $display("FAIL press_release_overlap: got %0d cycles expected 0", ovl);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    pc0[0] = 0; pc0[1] = 0;
    rc0[0] = 0; rc0[1] = 0;
    pc1 = 0; rc1 = 0; ovl = 0;
  end

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
Parametrised multi-channel push-button debouncer for the game's board inputs, such as flap and start. Each channel synchronises a raw asynchronous button and applies optional polarity inversion. It filters bounce symmetrically on both press and release. Per channel it outputs a clean level plus single-cycle press and release pulses for the game FSM.

Parameters:
NUM_CH, 4, number of independent button channels (>=1)
CNT_W, 16, stability counter width; stability window is 2^CNT_W cycles (>=1)
ACTIVE_LOW, 0, 1 = raw buttons are asserted low (inverted after synchroniser); applies to all channels
SYNC_STAGES, 2, flip-flop synchroniser depth per channel (>=2)

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_btn  input  NUM_CH  raw asynchronous button inputs, bit k = channel k
o_btn_state  output  NUM_CH  debounced level, 1 = pressed (after polarity normalisation)
o_press  output  NUM_CH  one-cycle pulse when o_btn_state goes 0->1
o_release  output  NUM_CH  one-cycle pulse when o_btn_state goes 1->0

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While i_rst_n=0, every channel is forced to STABLE_LO with counter 0.
  - Synchroniser flops reset to the inactive raw level (ACTIVE_LOW ? 1 : 0).
  - o_btn_state, o_press and o_release are all 0.
  - Reset mid-count abandons the count; no pulse is emitted on reset entry or exit.
- Synchroniser: SYNC_STAGES flops per channel. norm[k] = last stage XOR ACTIVE_LOW.
- Per-channel FSM, 4 states, with a CNT_W-bit counter:
  - STABLE_LO (o_btn_state=0): norm=1 -> CHECK_HI, cnt<=0; else stay, cnt<=0.
  - CHECK_HI: norm=0 -> STABLE_LO, cnt<=0, no output change (glitch rejected).
    - Else if cnt==2^CNT_W-1 -> STABLE_HI, cnt<=0, o_btn_state<=1, o_press<=1 for one cycle.
    - Else cnt<=cnt+1.
  - STABLE_HI (o_btn_state=1): norm=0 -> CHECK_LO, cnt<=0; else stay.
  - CHECK_LO: mirror of CHECK_HI with roles swapped.
    - norm=1 -> back to STABLE_HI.
    - Full count with norm=0 -> STABLE_LO, o_btn_state<=0, o_release<=1 for one cycle.
- The norm check takes priority over the terminal count. A drop on the terminal-count edge still rejects the transition.
- Acceptance rule: a level change is accepted only if norm holds the new value on 2^CNT_W+1 consecutive FSM sampling edges.
- Latency: o_btn_state changes SYNC_STAGES+2^CNT_W rising edges after the first edge at which the new raw level is captured by synchroniser stage 1. This holds provided the input is stable throughout.
- The counter never wraps; it is cleared on terminal count and on every state change.
- All outputs are registered.
  - o_press/o_release assert in the same cycle o_btn_state changes and are exactly 1 cycle wide.
  - o_press and o_release are never high together on one channel.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses with no arbitration.
- Input held continuously asserted: exactly one o_press, with no repeat, until released.

Test Plan:
- Reset: NUM_CH=2, CNT_W=4, ACTIVE_LOW=0; hold i_rst_n=0, toggle i_btn -> all outputs 0. Release reset with i_btn=0 -> no pulses.
- Clean press: i_btn[0] 0->1 captured at edge e0, held -> o_btn_state[0]=1 and o_press[0]=1 after edge e0+18. o_press[0] returns to 0 one cycle later. Channel 1 stays 0.
- Bounce rejection: i_btn[0] high for 16 cycles, then low -> no o_press. High for 17+ cycles -> press accepted. Bounce train of 1/3/2-cycle pulses followed by a steady level -> exactly one o_press, 18 edges after the final rising edge.
- Release and simultaneity: both channels pressed on the same cycle, then released on the same cycle -> o_press[1:0]=2'b11 on one cycle, later o_release[1:0]=2'b11 on one cycle. No extra pulses.
- Polarity: ACTIVE_LOW=1, idle i_btn=1, drive 0 and hold -> o_btn_state=1 after 18 edges. Return to 1 -> o_release after 18 edges.
- Reset mid-count: assert i_rst_n=0 while in CHECK_HI at cnt=10 -> outputs immediately 0 (asynchronous). After release with i_btn held 1 -> press occurs a full 18 edges after reset deassertion, not a partial count.
